// File: rtl/ws2812_rx.sv
// WS2812-style single-wire LED stream decoder: pulse-width bit decode,
// 24-bit GRB word assembly, latch-gap detection and per-frame word count.
module ws2812_rx #(
    parameter int unsigned BIT_THRESH   = 30,
    parameter int unsigned MIN_HIGH     = 8,
    parameter int unsigned MAX_HIGH     = 56,
    parameter int unsigned RESET_CYCLES = 2500,
    parameter int unsigned PIX_W        = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             din,
    output logic [23:0]      pix_data,
    output logic             pix_valid,
    output logic [PIX_W-1:0] pix_index,
    output logic             frame_done,
    output logic [PIX_W-1:0] frame_len,
    output logic             err
);

    localparam int unsigned CNT_W = $clog2(RESET_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_FULL  = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] HIGH_MAX  = CNT_W'(MAX_HIGH);
    localparam logic [CNT_W-1:0] HIGH_MIN  = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] THRESH    = CNT_W'(BIT_THRESH);
    localparam logic [4:0]       LAST_BIT  = 5'd23;
    localparam logic [PIX_W-1:0] WORD_MAX  = '1;

    typedef enum logic [1:0] {
        WAIT_RST = 2'd0,
        IDLE     = 2'd1,
        HIGH     = 2'd2,
        LOW      = 2'd3
    } state_t;

    state_t           state;
    logic             sync_1;
    logic             ds;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       bitcnt;
    logic [PIX_W-1:0] wordcnt;
    logic [23:0]      shreg;
    logic             word_rdy;

    // Two-flop synchronizer for the asynchronous data line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b0;
            ds     <= 1'b0;
        end else begin
            sync_1 <= din;
            ds     <= sync_1;
        end
    end

    // Decoder FSM: width measurement, bit/word assembly, latch and error pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= WAIT_RST;
            cnt        <= '0;
            bitcnt     <= '0;
            wordcnt    <= '0;
            shreg      <= '0;
            word_rdy   <= 1'b0;
            pix_data   <= '0;
            pix_valid  <= 1'b0;
            pix_index  <= '0;
            frame_done <= 1'b0;
            frame_len  <= '0;
            err        <= 1'b0;
        end else begin
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;

            // Publish a completed word one clock after its 24th bit was shifted in
            if (word_rdy) begin
                word_rdy  <= 1'b0;
                pix_data  <= shreg;
                pix_valid <= 1'b1;
                pix_index <= wordcnt;
                if (wordcnt != WORD_MAX) begin
                    wordcnt <= wordcnt + PIX_W'(1);
                end
            end

            case (state)
                WAIT_RST: begin
                    if (ds) begin
                        cnt <= '0;
                    end else if (cnt == RST_LAST) begin
                        cnt   <= RST_FULL;
                        state <= IDLE;
                    end else if (cnt != RST_FULL) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                IDLE: begin
                    if (ds) begin
                        cnt   <= CNT_ONE;
                        state <= HIGH;
                    end
                end

                HIGH: begin
                    if (ds) begin
                        if (cnt == HIGH_MAX) begin
                            err    <= 1'b1;
                            bitcnt <= '0;
                            cnt    <= '0;
                            state  <= WAIT_RST;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end else if (cnt < HIGH_MIN) begin
                        // Glitch: this falling cycle already counts as one low cycle
                        err    <= 1'b1;
                        bitcnt <= '0;
                        cnt    <= CNT_ONE;
                        state  <= WAIT_RST;
                    end else begin
                        shreg <= {shreg[22:0], (cnt > THRESH)};
                        if (bitcnt == LAST_BIT) begin
                            bitcnt   <= '0;
                            word_rdy <= 1'b1;
                        end else begin
                            bitcnt <= bitcnt + 5'd1;
                        end
                        cnt   <= CNT_ONE;
                        state <= LOW;
                    end
                end

                LOW: begin
                    if (ds) begin
                        cnt   <= CNT_ONE;
                        state <= HIGH;
                    end else if (cnt == RST_LAST) begin
                        // Latch gap: close the frame, flag a dangling partial word
                        frame_done <= 1'b1;
                        frame_len  <= wordcnt;
                        wordcnt    <= '0;
                        if (bitcnt != 5'd0) begin
                            err <= 1'b1;
                        end
                        bitcnt <= '0;
                        cnt    <= RST_FULL;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: begin
                    cnt   <= '0;
                    state <= WAIT_RST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_rx.sv
// Scoreboard bench for ws2812_rx: drives pulse-width encoded words and
// compares every pix_valid / frame_done / err pulse against queued expectations.
module tb_ws2812_rx;

    localparam int unsigned PIX_W = 10;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             din;
    logic [23:0]      pix_data;
    logic             pix_valid;
    logic [PIX_W-1:0] pix_index;
    logic             frame_done;
    logic [PIX_W-1:0] frame_len;
    logic             err;

    typedef struct packed {
        logic [23:0]      d;
        logic [PIX_W-1:0] i;
    } pix_t;

    typedef struct packed {
        logic [PIX_W-1:0] len;
        logic             e;
    } frm_t;

    pix_t exp_pix[$];
    frm_t exp_frm[$];
    int   err_pend = 0;
    int   total    = 0;
    int   bad      = 0;

    ws2812_rx dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .din        (din),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_index  (pix_index),
        .frame_done (frame_done),
        .frame_len  (frame_len),
        .err        (err)
    );

    // 50 MHz clock
    always #10 clk = ~clk;

    // Count a comparison and report a mismatch
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_pix(input logic [23:0] d, input int idx);
        pix_t p;
        p.d = d;
        p.i = PIX_W'(idx);
        exp_pix.push_back(p);
    endtask

    task automatic expect_frm(input int len, input logic e);
        frm_t f;
        f.len = PIX_W'(len);
        f.e   = e;
        exp_frm.push_back(f);
    endtask

    // One bit cell: hi cycles high then lo cycles low, aligned to negedge
    task automatic drive_bit(input int hi, input int lo);
        din = 1'b1;
        repeat (hi) @(negedge clk);
        din = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic idle(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // 24-bit word, MSB first; optional override of first high width and one low gap
    task automatic send_word(input logic [23:0] data, input int first_hi,
                             input int gap_bit, input int gap_len);
        int hi;
        int lo;
        for (int i = 23; i >= 0; i--) begin
            hi = data[i] ? 40 : 20;
            if (i == 23 && first_hi > 0) hi = first_hi;
            lo = 62 - hi;
            if (i == gap_bit) lo = gap_len;
            drive_bit(hi, lo);
        end
    endtask

    // Output monitor: pop and compare on every DUT pulse
    always @(negedge clk) begin : monitor
        pix_t p;
        frm_t f;
        if (reset_n) begin
            if (pix_valid || frame_done)
                check("valid_done_excl", 32'(pix_valid & frame_done), 32'd0);
            if (pix_valid) begin
                if (exp_pix.size() == 0) begin
                    check("pix_unexpected", 32'(pix_data), 32'hFFFF_FFFF);
                end else begin
                    p = exp_pix.pop_front();
                    check("pix_data", 32'(pix_data), 32'(p.d));
                    check("pix_index", 32'(pix_index), 32'(p.i));
                end
            end
            if (frame_done) begin
                if (exp_frm.size() == 0) begin
                    check("frame_unexpected", 32'(frame_len), 32'hFFFF_FFFF);
                end else begin
                    f = exp_frm.pop_front();
                    check("frame_len", 32'(frame_len), 32'(f.len));
                    check("frame_err", 32'(err), 32'(f.e));
                end
            end
            if (err && !frame_done) begin
                check("err_expected", 32'(err_pend > 0), 32'd1);
                if (err_pend > 0) err_pend--;
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        din     = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_pix_data", 32'(pix_data), 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_index", 32'(pix_index), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_frame_len", 32'(frame_len), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset_n = 1'b1;
        idle(2510);

        // Single word frame
        expect_pix(24'hA5C30F, 0);
        expect_frm(1, 1'b0);
        send_word(24'hA5C30F, 0, -1, 0);
        idle(2600);

        // Two identical three-word frames
        for (int f = 0; f < 2; f++) begin
            expect_pix(24'hFFFFFF, 0);
            expect_pix(24'h000000, 1);
            expect_pix(24'h123456, 2);
            expect_frm(3, 1'b0);
            send_word(24'hFFFFFF, 0, -1, 0);
            send_word(24'h000000, 0, -1, 0);
            send_word(24'h123456, 0, -1, 0);
            idle(2600);
        end

        // High-width boundaries on the first bit: 30->0, 31->1, 8->0 accepted, 56->1 accepted
        expect_pix(24'h7FFFFF, 0);
        expect_pix(24'h800000, 1);
        expect_pix(24'h2AAAAA, 2);
        expect_pix(24'hD55555, 3);
        expect_frm(4, 1'b0);
        send_word(24'hFFFFFF, 30, -1, 0);
        send_word(24'h000000, 31, -1, 0);
        send_word(24'hAAAAAA, 8, -1, 0);
        send_word(24'h555555, 56, -1, 0);
        idle(2600);

        // Glitch (7 high) then stuck-high (57): error, silence, then recovery
        for (int k = 0; k < 2; k++) begin
            err_pend++;
            if (k == 0) drive_bit(7, 55);
            else        drive_bit(57, 5);
            send_word(24'h0F0F0F, 0, -1, 0);
            idle(2600);
            expect_pix(24'h336699, 0);
            expect_frm(1, 1'b0);
            send_word(24'h336699, 0, -1, 0);
            idle(2600);
        end

        // Partial word at latch: err and frame_done together, no word
        expect_frm(0, 1'b1);
        for (int b = 0; b < 10; b++) drive_bit(20, 42);
        idle(2600);

        // Low gap of 2499 after the sixth bit is a normal bit gap
        expect_pix(24'h3C96E1, 0);
        expect_frm(1, 1'b0);
        send_word(24'h3C96E1, 0, 18, 2499);
        idle(2600);

        // Low gap of 2500 after the sixth bit is a latch with dangling bits
        expect_frm(0, 1'b1);
        for (int b = 0; b < 6; b++) drive_bit(40, (b == 5) ? 2500 : 22);
        idle(100);

        // Reset in the middle of bit 12 of the second word
        expect_pix(24'h5A5A5A, 0);
        send_word(24'h5A5A5A, 0, -1, 0);
        for (int b = 0; b < 12; b++) drive_bit(40, 22);
        din = 1'b1;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_pix_data", 32'(pix_data), 32'd0);
        check("mid_rst_pix_valid", 32'(pix_valid), 32'd0);
        check("mid_rst_pix_index", 32'(pix_index), 32'd0);
        check("mid_rst_frame_done", 32'(frame_done), 32'd0);
        check("mid_rst_frame_len", 32'(frame_len), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        @(negedge clk);
        din = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        idle(2510);
        expect_pix(24'hC0FFEE, 0);
        expect_frm(1, 1'b0);
        send_word(24'hC0FFEE, 0, -1, 0);
        idle(2600);

        // Every expected event must have been observed
        check("pix_left", 32'(exp_pix.size()), 32'd0);
        check("frm_left", 32'(exp_frm.size()), 32'd0);
        check("err_left", 32'(err_pend), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
